// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared widths, pass shifts and controller state encoding for
//               the sequential 6x6 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int HALF_W = 3;
    localparam int FULL_W = 2 * HALF_W;
    localparam int PROD_W = 2 * FULL_W;

    localparam int SH_LL  = 0;
    localparam int SH_MID = HALF_W;
    localparam int SH_HH  = 2 * HALF_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        LH   = 3'd2,
        HL   = 3'd3,
        HH   = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul3x3.sv
`default_nettype none
// ============================================================================
// Module      : mul3x3
// Description : Combinational unsigned array multiplier (W x W -> 2W).
// Revision    : 1.0 - initial release
// ============================================================================
module mul3x3 #(
    parameter int W = 3
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] w_row [W];

    // One AND-gated, left-shifted copy of a per bit of b
    for (genvar i = 0; i < W; i++) begin : g_row
        assign w_row[i] = {{W{1'b0}}, (a & {W{b[i]}})} << i;
    end

    always_comb begin
        p = '0;
        for (int j = 0; j < W; j++) begin
            p = p + w_row[j];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul6_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul6_seq_ctrl
// Description : Sequential 6x6 unsigned multiplier; four passes through one
//               shared 3x3 multiplier, summed into a 12-bit accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mul6_seq_ctrl #(
    parameter int HALF_W = mul_pkg::HALF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*HALF_W-1:0] p
);

    import mul_pkg::*;

    localparam int C_FW = 2 * HALF_W;
    localparam int C_PW = 4 * HALF_W;

    state_t              r_state;
    state_t              w_next;
    logic [C_FW-1:0]     r_a;
    logic [C_FW-1:0]     r_b;
    logic [C_PW-1:0]     r_acc;
    logic [C_PW-1:0]     r_p;
    logic [HALF_W-1:0]   w_mul_a;
    logic [HALF_W-1:0]   w_mul_b;
    logic [C_FW-1:0]     w_pp;
    logic [C_PW-1:0]     w_pp_ext;
    logic [C_PW-1:0]     w_term;
    logic                w_accept;

    mul3x3 #(.W(HALF_W)) u_mul (
        .a (w_mul_a),
        .b (w_mul_b),
        .p (w_pp)
    );

    assign w_pp_ext = {{(C_PW-C_FW){1'b0}}, w_pp};

    // Half-select mux; multiplier inputs parked at zero outside the passes
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        w_term  = '0;
        case (r_state)
            LL: begin
                w_mul_a = r_a[HALF_W-1:0];
                w_mul_b = r_b[HALF_W-1:0];
                w_term  = w_pp_ext << SH_LL;
            end
            LH: begin
                w_mul_a = r_a[HALF_W-1:0];
                w_mul_b = r_b[C_FW-1:HALF_W];
                w_term  = w_pp_ext << SH_MID;
            end
            HL: begin
                w_mul_a = r_a[C_FW-1:HALF_W];
                w_mul_b = r_b[HALF_W-1:0];
                w_term  = w_pp_ext << SH_MID;
            end
            HH: begin
                w_mul_a = r_a[C_FW-1:HALF_W];
                w_mul_b = r_b[C_FW-1:HALF_W];
                w_term  = w_pp_ext << SH_HH;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) w_next = LL;
            end
            LL: begin busy = 1'b1; w_next = LH; end
            LH: begin busy = 1'b1; w_next = HL; end
            HL: begin busy = 1'b1; w_next = HH; end
            HH: begin busy = 1'b1; w_next = DONE; end
            DONE: begin
                done     = 1'b1;
                w_accept = start;
                w_next   = start ? LL : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= '0;
            end else if (busy) begin
                r_acc <= r_acc + w_term;
            end
            // Final pass publishes the complete sum directly
            if (r_state == HH) begin
                r_p <= r_acc + w_term;
            end
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mul6_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul6_seq_ctrl
// Description : Directed self-checking bench for mul6_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul6_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  a = '0;
    logic [5:0]  b = '0;
    logic        busy;
    logic        done;
    logic [11:0] p;

    int checks = 0;
    int errors = 0;

    mul6_seq_ctrl #(.HALF_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 6'd5; b = 6'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || p !== 12'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: busy=%b done=%b p=%0d, want 0 0 0", i, busy, done, p);
            end
        end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic(input logic [5:0] ta, input logic [5:0] tb_, input logic [11:0] exp);
        a = ta; b = tb_; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy %0d*%0d pass%0d: busy=%b done=%b, want 1 0", ta, tb_, i, busy, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || p !== exp) begin
            errors++;
            $display("FAIL basic_done %0d*%0d: done=%b busy=%b p=%0d, want 1 0 %0d", ta, tb_, done, busy, p, exp);
        end
        tick();
        checks++;
        if (done !== 1'b0 || p !== exp) begin
            errors++;
            $display("FAIL basic_hold %0d*%0d: done=%b p=%0d, want 0 %0d", ta, tb_, done, p, exp);
        end
    endtask

    task automatic test_back_to_back();
        a = 6'd10; b = 6'd12; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        a = 6'd9; b = 6'd9;
        tick();
        checks++;
        if (done !== 1'b1 || p !== 12'd120) begin
            errors++;
            $display("FAIL b2b_first: done=%b p=%0d, want 1 120", done, p);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b done=%b, want 1 0", busy, done);
        end
        for (int i = 0; i < 2; i++) tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || p !== 12'd81) begin
            errors++;
            $display("FAIL b2b_second: done=%b p=%0d, want 1 81", done, p);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_ignore_while_busy();
        a = 6'd6; b = 6'd5; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            a = 6'd63 - 6'(i); b = 6'd63; start = (i % 2 == 0);
            tick();
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || p !== 12'd30) begin
            errors++;
            $display("FAIL busy_ignore: done=%b p=%0d, want 1 30", done, p);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op();
        a = 6'd7; b = 6'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 12'd0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b p=%0d, want 0 0 0", busy, done, p);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cyc%0d: done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
        test_basic(6'd3, 6'd3, 12'd9);
    endtask

    task automatic test_sweep();
        int  ops;
        logic [11:0] exp;
        ops = 0;
        start = 1'b1;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                a = 6'(i); b = 6'(j); start = 1'b1;
                exp = 12'(i * j);
                tick();
                a = 6'(j); b = 6'(i + 1);
                for (int k = 0; k < 3; k++) begin
                    if (done !== 1'b0) begin
                        checks++;
                        errors++;
                        $display("FAIL sweep_pulse %0d*%0d: done high in pass %0d", i, j, k);
                    end
                    tick();
                end
                tick();
                checks++;
                if (done !== 1'b1 || p !== exp) begin
                    errors++;
                    $display("FAIL sweep %0d*%0d: done=%b p=%0d, want 1 %0d", i, j, done, p, exp);
                end
                ops++;
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || ops != 4096) begin
            errors++;
            $display("FAIL sweep_end: done=%b ops=%0d, want 0 4096", done, ops);
        end
    endtask

    initial begin
        test_reset();
        test_basic(6'd5, 6'd7, 12'd35);
        test_basic(6'd63, 6'd63, 12'd3969);
        test_basic(6'd0, 6'd45, 12'd0);
        test_basic(6'd45, 6'd22, 12'd990);
        test_back_to_back();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
